// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths, constants and the fetch entry layout for the fetch front end
package riscv_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush and occupancy count
module fetch_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_empty,
    output logic             o_full,
    output logic [AW:0]      o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == (AW+1)'(DEPTH));
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];
    assign w_do_push  = i_push & ~o_full;
    assign w_do_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - fetch PC, in-order imem requests, response pairing and decode buffer; MISALIGN_TRAP_EN adds dec_misalign
module pc_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_add4,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc
`ifdef MISALIGN_TRAP_EN
    ,
    output logic            dec_misalign
`endif
);

    localparam int             CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);

    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   r_drop_cnt;
    logic [XLEN-1:0] w_addr_head;
    logic            w_addr_empty;
    logic            w_addr_full;
    logic [CW-1:0]   w_addr_count;
    logic            w_data_empty;
    logic            w_data_full;
    logic [CW-1:0]   w_data_count;
    fetch_entry_t    w_data_in;
    fetch_entry_t    w_data_head;
    logic [CW-1:0]   w_outstanding;
    logic            w_has_credit;
    logic            w_halted;
    logic            w_trap_push;
    logic            w_fire;
    logic            w_rsp_counted;
    logic            w_rsp_live;
    logic            w_data_push;
    logic [XLEN-1:0] w_redirect_target;

    // Every accepted request is either a live entry in the addr FIFO or a stale one still to be dropped.
    assign w_outstanding  = r_drop_cnt + w_addr_count;
    assign w_has_credit   = (w_outstanding + w_data_count) < DEPTH_C;
    assign imem_req_valid = ~rst & w_has_credit & ~redirect_valid & ~w_halted & ~w_addr_full;
    assign imem_req_addr  = r_pc;
    assign pc             = r_pc;
    assign w_fire         = imem_req_valid & imem_req_ready;
    assign w_rsp_counted  = imem_rsp_valid & ~redirect_valid;
    assign w_rsp_live     = w_rsp_counted & (r_drop_cnt == '0) & ~w_addr_empty;
    assign w_data_push    = (w_rsp_live | w_trap_push) & ~w_data_full;
    assign dec_valid      = ~w_data_empty;
    assign dec_pc         = w_data_head.pc;
    assign dec_instr      = w_data_head.instr;

`ifdef MISALIGN_TRAP_EN
    logic            r_halted;
    logic            r_trap_pend;
    logic [XLEN-1:0] r_trap_pc;

    assign w_redirect_target = redirect_pc;
    assign w_halted          = r_halted;
    assign w_trap_push       = r_trap_pend & ~redirect_valid;
    // Only the trap entry can sit in the data FIFO while halted.
    assign dec_misalign      = r_halted & dec_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halted    <= 1'b0;
            r_trap_pend <= 1'b0;
            r_trap_pc   <= '0;
        end else if (redirect_valid) begin
            r_halted    <= |redirect_pc[1:0];
            r_trap_pend <= |redirect_pc[1:0];
            r_trap_pc   <= redirect_pc;
        end else begin
            r_trap_pend <= 1'b0;
        end
    end

    always_comb begin
        w_data_in.pc    = w_addr_head;
        w_data_in.instr = imem_rsp_data;
        if (r_trap_pend) begin
            w_data_in.pc    = r_trap_pc;
            w_data_in.instr = NOP_INSTR;
        end
    end
`else
    assign w_redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_halted          = 1'b0;
    assign w_trap_push       = 1'b0;

    always_comb begin
        w_data_in.pc    = w_addr_head;
        w_data_in.instr = imem_rsp_data;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_drop_cnt <= '0;
        end else if (redirect_valid) begin
            // A response landing in the redirect cycle is itself discarded, so it leaves the drop count.
            r_pc       <= w_redirect_target;
            r_drop_cnt <= w_outstanding - CW'(imem_rsp_valid);
        end else begin
            if (w_fire) begin
                r_pc <= pc_add4;
            end
            if (w_rsp_counted && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - CW'(1);
            end
        end
    end

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_addr_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_fire),
        .i_push_data (r_pc),
        .i_pop       (w_rsp_live),
        .i_flush     (redirect_valid),
        .o_pop_data  (w_addr_head),
        .o_empty     (w_addr_empty),
        .o_full      (w_addr_full),
        .o_count     (w_addr_count)
    );

    fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(FIFO_DEPTH)) u_data_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_data_push),
        .i_push_data (w_data_in),
        .i_pop       (dec_valid & dec_ready),
        .i_flush     (redirect_valid),
        .o_pop_data  (w_data_head),
        .o_empty     (w_data_empty),
        .o_full      (w_data_full),
        .o_count     (w_data_count)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - randomized directed bench for pc_fetch_unit against a transaction-level reference model
module tb_pc_fetch_unit;
    import riscv_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc, pc_add4, redirect_pc, imem_req_addr, imem_rsp_data, dec_instr, dec_pc;
    logic        redirect_valid, imem_req_valid, imem_req_ready, imem_rsp_valid, dec_valid, dec_ready;
`ifdef MISALIGN_TRAP_EN
    logic        dec_misalign;
`endif

    always #5 clk = ~clk;
    assign pc_add4 = pc + 32'd4;

    pc_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .pc_add4        (pc_add4),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc)
`ifdef MISALIGN_TRAP_EN
        ,
        .dec_misalign   (dec_misalign)
`endif
    );

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          epoch = 0;
    int          buffered = 0;
    int          lat_lo = 1, lat_hi = 1, rdy_pct = 100, drdy_pct = 100;
    logic [31:0] exp_req = RPC;
    logic [31:0] exp_dec = RPC;
    logic        halted = 1'b0;
    logic        trap_pend = 1'b0;
    logic [31:0] trap_pc = '0;
    logic [31:0] q_addr[$];
    int          q_ep[$];
    int          q_due[$];
    logic        did;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, sample #1 later, advance the model, then wait for the next negedge.
    task automatic step(input logic redir, input logic [31:0] tgt, input logic redir_on_rsp, output logic done);
        logic rsp, r, pop, fire;
        int   due;
        rsp = (q_addr.size() > 0) && (q_due[0] <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? instr_of(q_addr[0]) : 32'h0;
        r = redir | (redir_on_rsp & rsp);
        redirect_valid = r;
        redirect_pc    = tgt;
        imem_req_ready = ($urandom_range(99) < rdy_pct);
        dec_ready      = ($urandom_range(99) < drdy_pct);
        #1;
        check("req_valid", 32'(imem_req_valid), 32'((q_addr.size() + buffered) < DEPTH && !r && !halted));
        check("pc", pc, exp_req);
        if (imem_req_valid) check("req_addr", imem_req_addr, exp_req);
        check("dec_valid", 32'(dec_valid), 32'(buffered > 0));
`ifdef MISALIGN_TRAP_EN
        check("dec_misalign", 32'(dec_misalign), 32'(buffered > 0 && halted));
`endif
        pop = dec_valid && dec_ready && !r && (buffered > 0);
        if (pop) begin
            if (halted) begin
                check("trap_pc", dec_pc, trap_pc);
                check("trap_instr", dec_instr, NOP_INSTR);
            end else begin
                check("dec_pc", dec_pc, exp_dec);
                check("dec_instr", dec_instr, instr_of(exp_dec));
                exp_dec += 32'd4;
            end
            buffered--;
        end
        if (rsp) begin
            if (q_ep[0] == epoch && !r) buffered++;
            void'(q_addr.pop_front());
            void'(q_ep.pop_front());
            void'(q_due.pop_front());
        end
        fire = imem_req_valid && imem_req_ready;
        if (fire) begin
            due = cyc + $urandom_range(lat_hi, lat_lo);
            if (q_due.size() > 0 && due < q_due[$]) due = q_due[$];
            q_addr.push_back(exp_req);
            q_ep.push_back(epoch);
            q_due.push_back(due);
            exp_req += 32'd4;
        end
        if (trap_pend && !r) begin
            buffered++;
            trap_pend = 1'b0;
        end
        if (r) begin
            epoch++;
            buffered = 0;
`ifdef MISALIGN_TRAP_EN
            halted    = (tgt[1:0] != 2'b00);
            trap_pend = halted;
            trap_pc   = tgt;
            exp_req   = tgt;
`else
            exp_req   = {tgt[31:2], 2'b00};
`endif
            exp_dec = exp_req;
        end
        done = r;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        logic d;
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, d);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        q_addr.delete(); q_ep.delete(); q_due.delete();
        epoch++; buffered = 0; halted = 1'b0; trap_pend = 1'b0;
        exp_req = RPC; exp_dec = RPC;
        redirect_valid = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b1; dec_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_pc", pc, RPC);
        check("rst_req_valid", 32'(imem_req_valid), 32'(0));
        check("rst_dec_valid", 32'(dec_valid), 32'(0));
        check("rst_dec_pc", dec_pc, 32'h0);
        check("rst_dec_instr", dec_instr, 32'h0);
`ifdef MISALIGN_TRAP_EN
        check("rst_dec_misalign", 32'(dec_misalign), 32'(0));
`endif
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0; dec_ready = 1'b0;
        @(negedge clk);
        apply_reset();

        // sequential fetch with single-cycle memory
        run(20);

        // decode back-pressure, then drain
        drdy_pct = 0;   run(10);
        drdy_pct = 100; run(12);

        // two requests in flight when the redirect lands
        lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 10 && q_addr.size() < 2; i++) run(1);
        check("two_outstanding", 32'(q_addr.size() >= 2), 32'(1));
        step(1'b1, 32'h0000_0200, 1'b0, did);
        run(15);

        // redirect coinciding with a response
        lat_lo = 2; lat_hi = 3;
        did = 1'b0;
        for (int i = 0; i < 30 && !did; i++) step(1'b0, 32'h0000_0280, 1'b1, did);
        check("redir_with_rsp", 32'(did), 32'(1));
        run(15);

        // imem stall
        rdy_pct = 0;   run(5);
        rdy_pct = 100; run(8);

        // unaligned target in the default build is masked
        step(1'b1, 32'h0000_0343, 1'b0, did);
        run(8);

`ifdef MISALIGN_TRAP_EN
        drdy_pct = 0;
        step(1'b1, 32'h0000_0202, 1'b0, did);
        run(6);
        drdy_pct = 100; run(4);
        step(1'b1, 32'h0000_0300, 1'b0, did);
        run(10);
`endif

        // randomized mix
        lat_lo = 1; lat_hi = 4; rdy_pct = 70; drdy_pct = 60;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) < 4) step(1'b1, $urandom & 32'h0000_FFFF, 1'b0, did);
            else step(1'b0, 32'h0, 1'b0, did);
        end

        // reset in the middle of traffic
        apply_reset();
        lat_lo = 1; lat_hi = 2; rdy_pct = 100; drdy_pct = 100;
        run(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
